// File: rtl/cdb_data_writer.sv
// cdb_data_writer
//
// Result-side owner of the data CDB. It takes completed results from the functional
// units, grants one per cycle, and stores the result in a per-reorder-buffer-entry
// register. Reservation stations snoop the flat CDB_data_data / CDB_data_valid buses
// to resolve their Qj/Qk tags. An entry's valid bit is cleared when its RB index is
// allocated at dispatch or retired at commit.
//
// Build option:
//   CDB_RR_ARB_EN  defined   -> round-robin arbitration with a registered pointer
//                  undefined -> fixed priority, lowest-numbered requester wins
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   fu_req         in   [FU_NUM]           FU i holds a result (held until granted)
//   fu_rb_index    in   [FU_NUM*RB_INDEX]  destination RB index per FU
//   fu_data        in   [FU_NUM*WORD_SIZE] result value per FU
//   fu_grant       out  [FU_NUM]           combinational one-hot grant
//   alloc_valid    in   dispatch allocates alloc_index
//   alloc_index    in   [RB_INDEX]
//   retire_valid   in   commit frees retire_index
//   retire_index   in   [RB_INDEX]
//   CDB_data_data  out  [WORD_SIZE*RB_SIZE] registered entry data
//   CDB_data_valid out  [RB_SIZE]           registered entry valid bits
//   bcast_valid    out  registered pulse: an entry was written on the last edge
//   bcast_index    out  [RB_INDEX]          the entry written on the last edge

module cdb_data_writer #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned RB_SIZE   = 8,
    parameter int unsigned RB_INDEX  = 3,
    parameter int unsigned FU_NUM    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FU_NUM-1:0]             fu_req,
    input  logic [FU_NUM*RB_INDEX-1:0]    fu_rb_index,
    input  logic [FU_NUM*WORD_SIZE-1:0]   fu_data,
    output logic [FU_NUM-1:0]             fu_grant,
    input  logic                          alloc_valid,
    input  logic [RB_INDEX-1:0]           alloc_index,
    input  logic                          retire_valid,
    input  logic [RB_INDEX-1:0]           retire_index,
    output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    output logic [RB_SIZE-1:0]            CDB_data_valid,
    output logic                          bcast_valid,
    output logic [RB_INDEX-1:0]           bcast_index
);

    localparam int unsigned FuIdxW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    logic [WORD_SIZE*RB_SIZE-1:0] data_q, data_d;
    logic [RB_SIZE-1:0]           valid_q, valid_d;
    logic                         bcast_valid_q;
    logic [RB_INDEX-1:0]          bcast_index_q;

    logic                         grant_any;
    logic [FuIdxW-1:0]            grant_idx;
    logic [FuIdxW-1:0]            cand_idx;
    int unsigned                  cand;
    logic [RB_INDEX-1:0]          wr_idx;
    logic [WORD_SIZE-1:0]         wr_data;

`ifdef CDB_RR_ARB_EN
    logic [FuIdxW-1:0]            ptr_q, ptr_d;
`endif

    // Grant search depends only on fu_req and the registered pointer, so no
    // combinational path exists from fu_data / fu_rb_index to fu_grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < FU_NUM; k++) begin
`ifdef CDB_RR_ARB_EN
            cand = (32'(ptr_q) + k) % FU_NUM;
`else
            cand = k;
`endif
            cand_idx = cand[FuIdxW-1:0];
            if (!grant_any && fu_req[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        fu_grant = '0;
        if (grant_any) begin
            fu_grant[grant_idx] = 1'b1;
        end
    end

    assign wr_idx  = fu_rb_index[grant_idx*RB_INDEX +: RB_INDEX];
    assign wr_data = fu_data[grant_idx*WORD_SIZE +: WORD_SIZE];

    // Same-index conflicts resolve in the order write, retire, alloc: the later
    // assignment wins, so a clear from retire/alloc beats a same-edge write while
    // the written data is still kept.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (grant_any) begin
            data_d[wr_idx*WORD_SIZE +: WORD_SIZE] = wr_data;
            valid_d[wr_idx]                       = 1'b1;
        end
        if (retire_valid) begin
            valid_d[retire_index] = 1'b0;
        end
        if (alloc_valid) begin
            valid_d[alloc_index] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q        <= '0;
            valid_q       <= '0;
            bcast_valid_q <= 1'b0;
            bcast_index_q <= '0;
        end else begin
            data_q        <= data_d;
            valid_q       <= valid_d;
            bcast_valid_q <= grant_any;
            if (grant_any) begin
                bcast_index_q <= wr_idx;
            end
        end
    end

`ifdef CDB_RR_ARB_EN
    // Pointer moves to one past the winner; holds when nobody is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = FuIdxW'((32'(grant_idx) + 1) % FU_NUM);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign CDB_data_data  = data_q;
    assign CDB_data_valid = valid_q;
    assign bcast_valid    = bcast_valid_q;
    assign bcast_index    = bcast_index_q;

endmodule

// File: tb/tb_cdb_data_writer.sv
// Self-checking bench for cdb_data_writer. Stimulus pushes the expected broadcast
// (index, slot data, full valid vector) into a queue; a monitor on the falling edge
// pops and compares whenever bcast_valid is high.

module tb_cdb_data_writer;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int F  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [F-1:0]    fu_req = '0;
    logic [F*IW-1:0] fu_rb_index = '0;
    logic [F*W-1:0]  fu_data = '0;
    logic [F-1:0]    fu_grant;
    logic            alloc_valid = 1'b0;
    logic [IW-1:0]   alloc_index = '0;
    logic            retire_valid = 1'b0;
    logic [IW-1:0]   retire_index = '0;
    logic [W*N-1:0]  CDB_data_data;
    logic [N-1:0]    CDB_data_valid;
    logic            bcast_valid;
    logic [IW-1:0]   bcast_index;

    always #5 clk = ~clk;

    cdb_data_writer #(
        .WORD_SIZE(W),
        .RB_SIZE  (N),
        .RB_INDEX (IW),
        .FU_NUM   (F)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fu_req        (fu_req),
        .fu_rb_index   (fu_rb_index),
        .fu_data       (fu_data),
        .fu_grant      (fu_grant),
        .alloc_valid   (alloc_valid),
        .alloc_index   (alloc_index),
        .retire_valid  (retire_valid),
        .retire_index  (retire_index),
        .CDB_data_data (CDB_data_data),
        .CDB_data_valid(CDB_data_valid),
        .bcast_valid   (bcast_valid),
        .bcast_index   (bcast_index)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        logic [N-1:0]  vld;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every broadcast must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bcast_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_bcast: got index %0d, want no broadcast", bcast_index);
            end else begin
                e = sb.pop_front();
                chk("bcast_index", 64'(bcast_index), 64'(e.idx));
                chk("slot_data", 64'(CDB_data_data[e.idx*W +: W]), 64'(e.data));
                chk("valid_vec", 64'(CDB_data_valid), 64'(e.vld));
            end
        end
    end

    task automatic set_fu(input int i, input logic [IW-1:0] idx, input logic [W-1:0] d);
        fu_rb_index[i*IW +: IW] = idx;
        fu_data[i*W +: W]       = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-requester write; expected grant is the requester's one-hot.
    task automatic write1(input int fu, input logic [IW-1:0] idx, input logic [W-1:0] d,
                          input logic [N-1:0] vld);
        logic [F-1:0] g;
        g = '0;
        g[fu] = 1'b1;
        set_fu(fu, idx, d);
        fu_req = g;
        #1;
        chk("grant_single", 64'(fu_grant), 64'(g));
        sb.push_back('{idx: idx, data: d, vld: vld});
        step();
        fu_req = '0;
    endtask

    logic [N-1:0]  fill_v [8];
    logic [F-1:0]  c_grant[4];
    logic [IW-1:0] c_idx  [4];
    logic [W-1:0]  c_data [4];
    logic [N-1:0]  c_vld  [4];

    initial begin
        fill_v = '{8'h29, 8'h2B, 8'h2F, 8'h2F, 8'h3F, 8'h3F, 8'h7F, 8'hFF};
`ifdef CDB_RR_ARB_EN
        c_grant = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        c_idx   = '{3'd1, 3'd2, 3'd4, 3'd1};
        c_data  = '{32'hA0, 32'hA1, 32'hA3, 32'hA0};
        c_vld   = '{8'h02, 8'h06, 8'h16, 8'h16};
`else
        c_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        c_idx   = '{3'd1, 3'd1, 3'd1, 3'd1};
        c_data  = '{32'hA0, 32'hA0, 32'hA0, 32'hA0};
        c_vld   = '{8'h02, 8'h02, 8'h02, 8'h02};
`endif

        // Reset held with all FUs requesting.
        for (int i = 0; i < F; i++) begin
            set_fu(i, IW'(i), 32'h1000 + 32'(i));
        end
        fu_req = 4'b1111;
        step();
        step();
        chk("rst_valid", 64'(CDB_data_valid), 64'h0);
        chk("rst_data_any", 64'(|CDB_data_data), 64'h0);
        chk("rst_bcast", 64'(bcast_valid), 64'h0);

        // First grant after release goes to FU0.
        reset = 1'b1;
        #1;
        chk("grant_after_rst", 64'(fu_grant), 64'h1);
        sb.push_back('{idx: 3'd0, data: 32'h1000, vld: 8'h01});
        step();
        fu_req = '0;
        #1;
        chk("grant_idle", 64'(fu_grant), 64'h0);

        // Single write: FU2 -> index 5.
        write1(2, 3'd5, 32'hDEADBEEF, 8'h21);

        // Retire keeps data, then alloc + rewrite.
        write1(3, 3'd3, 32'h33, 8'h29);
        retire_valid = 1'b1;
        retire_index = 3'd3;
        step();
        retire_valid = 1'b0;
        chk("retire_valid", 64'(CDB_data_valid), 64'h21);
        chk("retire_data", 64'(CDB_data_data[3*W +: W]), 64'h33);
        alloc_valid = 1'b1;
        alloc_index = 3'd3;
        step();
        alloc_valid = 1'b0;
        chk("alloc_valid", 64'(CDB_data_valid), 64'h21);
        write1(1, 3'd3, 32'h42, 8'h29);

        // Write and alloc on the same index at the same edge.
        set_fu(0, 3'd6, 32'h77);
        fu_req      = 4'b0001;
        alloc_valid = 1'b1;
        alloc_index = 3'd6;
        #1;
        chk("grant_conflict", 64'(fu_grant), 64'h1);
        sb.push_back('{idx: 3'd6, data: 32'h77, vld: 8'h29});
        step();
        fu_req      = '0;
        alloc_valid = 1'b0;

        // Fill every entry, back to back.
        for (int k = 0; k < N; k++) begin
            write1(0, IW'(k), 32'h100 + 32'(k), fill_v[k]);
        end
        step();
        chk("fill_valid", 64'(CDB_data_valid), 64'hFF);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(CDB_data_valid), 64'h0);
        chk("mid_rst_data_any", 64'(|CDB_data_data), 64'h0);
        chk("mid_rst_bcast", 64'(bcast_valid), 64'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Contention with 1011 held; pointer must restart from 0.
        set_fu(0, 3'd1, 32'hA0);
        set_fu(1, 3'd2, 32'hA1);
        set_fu(2, 3'd7, 32'hA2);
        set_fu(3, 3'd4, 32'hA3);
        fu_req = 4'b1011;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("grant_contend", 64'(fu_grant), 64'(c_grant[c]));
            sb.push_back('{idx: c_idx[c], data: c_data[c], vld: c_vld[c]});
            step();
        end
        fu_req = '0;
        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
